// File: rtl/hamming_enc_arbiter_pkg.sv
// Shared definitions for the Hamming(15,11) encoder arbiter: code sizes,
// output-stage state encoding and a reusable round-robin priority search.
package hamming_enc_arbiter_pkg;

    localparam int DATA_W  = 11;
    localparam int CODE_W  = 15;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Circular search for the first set bit of valid, starting at ptr and
    // wrapping at n-1 -> 0. Returns 0 when nothing is set; callers qualify
    // the result with |valid.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && valid[idx]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/hamming_enc_arbiter_calcula_hamming.sv
// Combinational Hamming(15,11) encoder. Codeword bit p-1 holds code
// position p (1..15); parity bits sit at positions 1,2,4,8 and data bits
// fill the remaining positions in ascending order.
module calcula_hamming
    import hamming_enc_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    // Code position of each data bit.
    localparam int POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    // Data bits covered by parity bit k (those whose position has bit k set).
    function automatic logic [DATA_W-1:0] cover_mask(input int k);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = ((POS[i] >> k) & 1) == 1;
        end
        return m;
    endfunction

    genvar gi;

    // Scatter data bits into their non-power-of-two positions.
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_data
            assign code[POS[gi]-1] = data[gi];
        end
    endgenerate

    // Even parity over each covered group, placed at position 2^k.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_par
            localparam logic [DATA_W-1:0] MASK = cover_mask(gi);
            assign code[(1 << gi) - 1] = ^(data & MASK);
        end
    endgenerate

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter in front of one shared Hamming(15,11) encoder, with a
// single-entry valid/ready output register tagged with the source index.
module hamming_enc_arbiter
    import hamming_enc_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [CODE_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        word_cnt
);

    state_t              state_reg;
    logic [CODE_W-1:0]   out_data_reg;
    logic [SRC_W-1:0]    out_src_reg;
    logic [SRC_W-1:0]    rr_ptr_reg;
    logic [CNT_W-1:0]    word_cnt_reg;

    logic [MAX_REQ-1:0]  valid_ext;
    logic [2:0]          ptr_ext;
    logic [2:0]          grant_idx;
    logic [SRC_W-1:0]    grant_src;
    logic                load;
    logic                accept;
    logic [DATA_W-1:0]   data_arr [N_REQ];
    logic [DATA_W-1:0]   sel_data;
    logic [CODE_W-1:0]   enc_code;

    genvar gi;

    assign out_valid = (state_reg == FULL);
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign word_cnt  = word_cnt_reg;
    assign busy      = out_valid || (|req_valid);

    // The output register can take a word when empty or being drained now.
    assign load   = (state_reg == EMPTY) || (out_ready && out_valid);
    assign accept = !rst && load && (|req_valid);

    // Widen request vector and pointer to the package search width.
    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = req_valid;
        ptr_ext                = '0;
        ptr_ext[SRC_W-1:0]     = rr_ptr_reg;
    end

    assign grant_idx = rr_pick(valid_ext, ptr_ext, N_REQ);
    assign grant_src = grant_idx[SRC_W-1:0];

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[DATA_W*gi +: DATA_W];
            assign req_ready[gi] = accept && (grant_src == SRC_W'(gi));
        end
    endgenerate

    assign sel_data = data_arr[grant_src];

    calcula_hamming u_enc (
        .data (sel_data),
        .code (enc_code)
    );

    // Output-stage FSM, round-robin pointer and accepted-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            out_data_reg <= '0;
            out_src_reg  <= '0;
            rr_ptr_reg   <= '0;
            word_cnt_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready && !accept) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
            if (accept) begin
                out_data_reg <= enc_code;
                out_src_reg  <= grant_src;
                rr_ptr_reg   <= (grant_src == SRC_W'(N_REQ - 1)) ? '0 : grant_src + SRC_W'(1);
                word_cnt_reg <= word_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule
